multicycle_control: RTL and testbench

- Main control FSM for the multicycle RV32I datapath.
- Decodes the latched instruction fields and sequences the datapath each cycle by driving PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource and the 4-bit ALU control.
- Supported instructions: lw, sw, addi, R-type add/sub/and/or, beq.
- Any other opcode is trapped.

---
 rtl/multicycle_ctrl_pkg.sv | 32 +++
 rtl/multicycle_control_alu_decoder.sv | 16 +
 rtl/multicycle_control.sv | 155 +++++++++++++++
 tb/tb_multicycle_control.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: state encoding, opcodes, ALU codes and ALUSrcB selects for the multicycle RV32I control.
package multicycle_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC_R   = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_EXEC_I   = 4'd8,
    S_ITYPE_WB = 4'd9,
    S_BRANCH   = 4'd10,
    S_BR_NT    = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  // Byte step the datapath applies when ALUSrcB selects the constant.
  localparam int PC_INC = 4;
endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// alu_decoder: maps R-type funct fields to an ALU operation and flags unsupported funct3.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic       is_rtype,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_ctrl,
  output logic       illegal_funct
);
  assign alu_ctrl = !is_rtype             ? ALU_ADD :
                    funct3 == 3'b111      ? ALU_AND :
                    funct3 == 3'b110      ? ALU_OR  :
                    (funct3 == 3'b000 && funct7_5) ? ALU_SUB : ALU_ADD;
  assign illegal_funct = is_rtype && !(funct3 inside {3'b000, 3'b110, 3'b111});
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main Moore control FSM sequencing the multicycle RV32I datapath.
// Optional performance counters are enabled with MULTICYCLE_CTRL_PERF_EN.
module multicycle_control
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_source,
  output logic [3:0] alu_ctrl,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);
  state_t     state_q, state_d;
  logic [3:0] dec_alu_ctrl;
  logic       illegal_funct;
  logic       pc4;

  alu_decoder u_alu_decoder (
    .is_rtype     (opcode == OPC_OP),
    .funct3       (funct3),
    .funct7_5     (funct7_5),
    .alu_ctrl     (dec_alu_ctrl),
    .illegal_funct(illegal_funct)
  );

  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_source  = 1'b0;
    alu_ctrl   = ALU_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;
    pc4        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OPC_LOAD || opcode == OPC_STORE) ? S_MEMADR :
                    opcode == OPC_OP     ? S_EXEC_R :
                    opcode == OPC_OP_IMM ? S_EXEC_I :
                    opcode == OPC_BRANCH ? S_BRANCH : S_ILLEGAL;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = opcode == OPC_LOAD ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        pc4        = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        pc4       = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_ctrl  = dec_alu_ctrl;
        state_d   = illegal_funct ? S_ILLEGAL : S_RTYPE_WB;
      end
      S_RTYPE_WB, S_ITYPE_WB: begin
        reg_write = 1'b1;
        pc4       = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ITYPE_WB;
      end
      // Taken branch retires here; the only Mealy-style outputs in the FSM.
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_ctrl   = ALU_SUB;
        pc_write   = zero;
        pc_source  = zero;
        instr_done = zero;
        state_d    = zero ? S_FETCH : S_BR_NT;
      end
      S_BR_NT:   pc4 = 1'b1;
      S_ILLEGAL: illegal = 1'b1;
      default:   state_d = S_FETCH;
    endcase
    if (pc4) begin
      pc_write   = 1'b1;
      alu_src_b  = SRCB_FOUR;
      instr_done = 1'b1;
      state_d    = S_FETCH;
    end
  end

  assign state = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_count_q, cycle_count_d, instr_count_q, instr_count_d;

  always_comb begin
    cycle_count_d = state_q != S_ILLEGAL ? cycle_count_q + 32'd1 : cycle_count_q;
    instr_count_d = instr_done ? instr_count_q + 32'd1 : instr_count_q;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end

  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for multicycle_control; per-cycle expectations are queued by the driver and checked by a monitor.
module tb_multicycle_control;
  import multicycle_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;
  logic       pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write;
  logic       alu_src_a, pc_source, instr_done, illegal;
  logic [1:0] alu_src_b;
  logic [3:0] alu_ctrl, state;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_count, instr_count;
`endif

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5), .zero(zero),
    .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .alu_ctrl(alu_ctrl), .state(state), .instr_done(instr_done), .illegal(illegal)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_source;
    logic [3:0] alu_ctrl;
    logic       instr_done, illegal;
  } obs_t;

  obs_t exp_q[$];
  obs_t act;
  int   checks = 0;
  int   errors = 0;

  assign act = {state, pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, pc_source, alu_ctrl, instr_done, illegal};

  // Action letters: R read, I iord, W write, J IR load, M mem_to_reg, G reg_write,
  // A src_a=A, m src_b=imm, 4 PC+4 bundle, T taken branch, X trap.
  function automatic obs_t mk(state_t s, string acts, logic [3:0] ctrl);
    obs_t o = '0;
    o.st = s;
    o.alu_ctrl = ctrl;
    for (int i = 0; i < acts.len(); i++)
      case (acts[i])
        "R": o.mem_read = 1'b1;
        "I": o.iord = 1'b1;
        "W": o.mem_write = 1'b1;
        "J": o.ir_write = 1'b1;
        "M": o.mem_to_reg = 1'b1;
        "G": o.reg_write = 1'b1;
        "A": o.alu_src_a = 1'b1;
        "m": o.alu_src_b = 2'b10;
        "4": begin o.pc_write = 1'b1; o.alu_src_b = 2'b01; o.instr_done = 1'b1; end
        "T": begin o.pc_write = 1'b1; o.pc_source = 1'b1; o.instr_done = 1'b1; end
        "X": o.illegal = 1'b1;
        default: ;
      endcase
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // Queue the cycle-by-cycle expectation for one instruction, then let it run.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input int hold);
    int         n;
    logic [3:0] c;
    logic       ok;
    opcode = op; funct3 = f3; funct7_5 = f7; zero = z;
    exp_q.push_back(mk(S_FETCH, "RJ", ALU_ADD));
    exp_q.push_back(mk(S_DECODE, "m", ALU_ADD));
    n = 2;
    ok = 1'b1;
    c = ALU_ADD;
    if (f3 == 3'b000) c = f7 ? ALU_SUB : ALU_ADD;
    else if (f3 == 3'b110) c = ALU_OR;
    else if (f3 == 3'b111) c = ALU_AND;
    else ok = 1'b0;
    if (op == OPC_LOAD) begin
      exp_q.push_back(mk(S_MEMADR, "Am", ALU_ADD));
      exp_q.push_back(mk(S_MEMRD, "RI", ALU_ADD));
      exp_q.push_back(mk(S_MEMWB, "GM4", ALU_ADD));
      n += 3;
    end else if (op == OPC_STORE) begin
      exp_q.push_back(mk(S_MEMADR, "Am", ALU_ADD));
      exp_q.push_back(mk(S_MEMWR, "WI4", ALU_ADD));
      n += 2;
    end else if (op == OPC_OP_IMM) begin
      exp_q.push_back(mk(S_EXEC_I, "Am", ALU_ADD));
      exp_q.push_back(mk(S_ITYPE_WB, "G4", ALU_ADD));
      n += 2;
    end else if (op == OPC_OP && ok) begin
      exp_q.push_back(mk(S_EXEC_R, "A", c));
      exp_q.push_back(mk(S_RTYPE_WB, "G4", ALU_ADD));
      n += 2;
    end else if (op == OPC_OP) begin
      exp_q.push_back(mk(S_EXEC_R, "A", ALU_ADD));
      n += 1;
      for (int i = 0; i < hold; i++) exp_q.push_back(mk(S_ILLEGAL, "X", ALU_ADD));
      n += hold;
    end else if (op == OPC_BRANCH && z) begin
      exp_q.push_back(mk(S_BRANCH, "AT", ALU_SUB));
      n += 1;
    end else if (op == OPC_BRANCH) begin
      exp_q.push_back(mk(S_BRANCH, "A", ALU_SUB));
      exp_q.push_back(mk(S_BR_NT, "4", ALU_ADD));
      n += 2;
    end else begin
      for (int i = 0; i < hold; i++) exp_q.push_back(mk(S_ILLEGAL, "X", ALU_ADD));
      n += hold;
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset_release();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  always @(negedge clk)
    if (exp_q.size() > 0) begin
      obs_t e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL cycle_obs: got %h (state %0d) expected %h (state %0d)", act, act.st, e, e.st);
      end
    end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {28'd0, state}, 32'd0);
    chk("rst_fetch_outs", {29'd0, mem_read, ir_write, pc_write}, 32'b110);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    reset = 1'b1;
    run_instr(OPC_OP_IMM, 3'b000, 1'b0, 1'b0, 0);
    run_instr(OPC_LOAD, 3'b010, 1'b0, 1'b0, 0);
    run_instr(OPC_OP, 3'b000, 1'b1, 1'b0, 0);
    run_instr(OPC_OP, 3'b000, 1'b0, 1'b0, 0);
    run_instr(OPC_OP, 3'b110, 1'b0, 1'b0, 0);
    run_instr(OPC_OP, 3'b111, 1'b0, 1'b0, 0);
    run_instr(OPC_BRANCH, 3'b000, 1'b0, 1'b1, 0);
    run_instr(OPC_BRANCH, 3'b000, 1'b0, 1'b0, 0);
    run_instr(OPC_STORE, 3'b010, 1'b0, 1'b0, 0);
    for (int i = 0; i < 60; i++) begin
      int         k;
      logic [6:0] op;
      logic [2:0] f3;
      k = $urandom_range(4);
      op = k == 0 ? OPC_LOAD : k == 1 ? OPC_STORE : k == 2 ? OPC_OP : k == 3 ? OPC_OP_IMM : OPC_BRANCH;
      k = $urandom_range(2);
      f3 = k == 0 ? 3'b000 : k == 1 ? 3'b110 : 3'b111;
      run_instr(op, f3, 1'($urandom_range(1)), 1'($urandom_range(1)), 0);
    end
    run_instr(OPC_OP, 3'b010, 1'b0, 1'b0, 6);
    #2 reset = 1'b0;
    #1 chk("funct_trap_rst_state", {28'd0, state}, 32'd0);
    chk("funct_trap_rst_illegal", {31'd0, illegal}, 32'd0);
    pulse_reset_release();
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 20);
    chk("trap_held", {31'd0, illegal}, 32'd1);
    #2 reset = 1'b0;
    #1 chk("trap_async_rst_state", {28'd0, state}, 32'd0);
    chk("trap_async_rst_illegal", {31'd0, illegal}, 32'd0);
    chk("trap_async_rst_fetch", {30'd0, mem_read, ir_write}, 32'b11);
    pulse_reset_release();
    opcode = OPC_STORE; funct3 = 3'b010; funct7_5 = 1'b0; zero = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("memwr_before_rst", {28'd0, mem_write, pc_write, 2'd0, state}, {28'd0, 1'b1, 1'b1, 2'd0, 4'(S_MEMWR)} >> 0);
    #1 reset = 1'b0;
    #1 chk("memwr_abort_state", {28'd0, state}, 32'd0);
    chk("memwr_abort_enables", {29'd0, mem_write, pc_write, reg_write}, 32'd0);
    pulse_reset_release();
    run_instr(OPC_OP_IMM, 3'b000, 1'b0, 1'b0, 0);
    run_instr(OPC_OP_IMM, 3'b000, 1'b0, 1'b0, 0);
    run_instr(OPC_OP_IMM, 3'b000, 1'b0, 1'b0, 0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("perf_instr_count", instr_count, 32'd3);
    chk("perf_cycle_count", cycle_count, 32'd12);
`endif
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
